// File: rtl/safety_threshold_monitor.sv
// Debounced NORMAL/WARN/CRIT/HOLD alarm classifier for accel magnitude and brake rate features.
// Optional macro SAFETY_EVT_COUNT_EN enables the saturating crit_events counter; otherwise the port is tied to 0.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module safety_threshold_monitor #(
  parameter int unsigned DW            = `DATA_WIDTH,
  parameter int unsigned ACCEL_WARN_TH = 800,
  parameter int unsigned ACCEL_CRIT_TH = 1200,
  parameter int unsigned BRAKE_WARN_TH = 500,
  parameter int unsigned BRAKE_CRIT_TH = 900,
  parameter int unsigned PERSIST       = 4,
  parameter int unsigned CLEAR_PERSIST = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] feat_accel_mag,
  input  logic [DW-1:0] feat_brake_rate,
  input  logic          data_valid,
  input  logic          alarm_ack,
  output logic [1:0]    state,
  output logic          warn,
  output logic          crit,
  output logic [1:0]    fault_code,
  output logic [7:0]    crit_events
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_WARN   = 2'd1,
    ST_CRIT   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int CW = $clog2(PERSIST + 1);
  localparam int RW = $clog2(CLEAR_PERSIST + 1);

  localparam logic [DW-1:0] ACCEL_WARN = DW'(ACCEL_WARN_TH);
  localparam logic [DW-1:0] ACCEL_CRIT = DW'(ACCEL_CRIT_TH);
  localparam logic [DW-1:0] BRAKE_WARN = DW'(BRAKE_WARN_TH);
  localparam logic [DW-1:0] BRAKE_CRIT = DW'(BRAKE_CRIT_TH);
  localparam logic [CW-1:0] PERSIST_V  = CW'(PERSIST);
  localparam logic [RW-1:0] CLEAR_V    = RW'(CLEAR_PERSIST);

  state_t        state_q, state_d;
  logic [CW-1:0] crit_cnt_q, crit_cnt_d;
  logic [CW-1:0] warn_cnt_q, warn_cnt_d;
  logic [RW-1:0] clr_cnt_q, clr_cnt_d;
  logic [1:0]    fault_code_q, fault_code_d;

  logic accel_crit, brake_crit, is_crit, is_warn;
  logic [CW-1:0] crit_inc, warn_inc;
  logic [RW-1:0] clr_inc;
  logic crit_reach, warn_reach, clr_reach, enter_crit;

  assign accel_crit = (feat_accel_mag >= ACCEL_CRIT);
  assign brake_crit = (feat_brake_rate >= BRAKE_CRIT);
  assign is_crit    = accel_crit | brake_crit;
  assign is_warn    = (feat_accel_mag >= ACCEL_WARN) | (feat_brake_rate >= BRAKE_WARN);

  assign crit_inc = (crit_cnt_q == PERSIST_V) ? crit_cnt_q : crit_cnt_q + CW'(1);
  assign warn_inc = (warn_cnt_q == PERSIST_V) ? warn_cnt_q : warn_cnt_q + CW'(1);
  assign clr_inc  = (clr_cnt_q == CLEAR_V) ? clr_cnt_q : clr_cnt_q + RW'(1);

  // Next-state and persistence counters; counters only move on valid samples.
  always_comb begin
    crit_cnt_d = crit_cnt_q;
    warn_cnt_d = warn_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    state_d    = state_q;
    if (data_valid) begin
      crit_cnt_d = is_crit ? crit_inc : '0;
      warn_cnt_d = is_warn ? warn_inc : '0;
      case (state_q)
        ST_WARN: clr_cnt_d = is_warn ? '0 : clr_inc;
        ST_CRIT: clr_cnt_d = is_crit ? '0 : clr_inc;
        default: clr_cnt_d = '0;
      endcase
    end
    crit_reach = data_valid && (crit_cnt_d == PERSIST_V);
    warn_reach = data_valid && (warn_cnt_d == PERSIST_V);
    clr_reach  = data_valid && (clr_cnt_d == CLEAR_V);
    case (state_q)
      ST_NORMAL: begin
        if (crit_reach)      state_d = ST_CRIT;
        else if (warn_reach) state_d = ST_WARN;
      end
      ST_WARN: begin
        if (crit_reach)      state_d = ST_CRIT;
        else if (clr_reach)  state_d = ST_NORMAL;
      end
      ST_CRIT: begin
        if (clr_reach)       state_d = ST_HOLD;
      end
      default: begin
        if (crit_reach)      state_d = ST_CRIT;
        else if (alarm_ack)  state_d = ST_NORMAL;
      end
    endcase
    if (state_d != state_q) begin
      crit_cnt_d = '0;
      warn_cnt_d = '0;
      clr_cnt_d  = '0;
    end
  end

  // Fault cause is captured from the sample that completes the CRIT run.
  always_comb begin
    enter_crit   = (state_d == ST_CRIT) && (state_q != ST_CRIT);
    fault_code_d = fault_code_q;
    if (enter_crit)
      fault_code_d = {brake_crit, accel_crit};
    else if ((state_d == ST_NORMAL) && (state_q != ST_NORMAL))
      fault_code_d = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_NORMAL;
      crit_cnt_q   <= '0;
      warn_cnt_q   <= '0;
      clr_cnt_q    <= '0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      crit_cnt_q   <= crit_cnt_d;
      warn_cnt_q   <= warn_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

`ifdef SAFETY_EVT_COUNT_EN
  logic [7:0] crit_events_q, crit_events_d;

  always_comb begin
    crit_events_d = crit_events_q;
    if (enter_crit && (crit_events_q != 8'hFF))
      crit_events_d = crit_events_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) crit_events_q <= 8'd0;
    else        crit_events_q <= crit_events_d;
  end

  assign crit_events = crit_events_q;
`else
  assign crit_events = 8'd0;
`endif

  assign state      = state_q;
  assign warn       = (state_q == ST_WARN);
  assign crit       = (state_q == ST_CRIT) || (state_q == ST_HOLD);
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_safety_threshold_monitor.sv
// Directed self-checking bench for safety_threshold_monitor using immediate assertions.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_safety_threshold_monitor;
  localparam int DW = `DATA_WIDTH;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] feat_accel_mag;
  logic [DW-1:0] feat_brake_rate;
  logic          data_valid;
  logic          alarm_ack;
  logic [1:0]    state;
  logic          warn;
  logic          crit;
  logic [1:0]    fault_code;
  logic [7:0]    crit_events;

  int checks = 0;
  int errors = 0;

  safety_threshold_monitor dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .feat_accel_mag  (feat_accel_mag),
    .feat_brake_rate (feat_brake_rate),
    .data_valid      (data_valid),
    .alarm_ack       (alarm_ack),
    .state           (state),
    .warn            (warn),
    .crit            (crit),
    .fault_code      (fault_code),
    .crit_events     (crit_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs at the falling edge, then settle just past the rising edge.
  task automatic applyStimulus(input int accel, input int brake, input logic dv, input logic ack);
    @(negedge clk);
    feat_accel_mag  = DW'(accel);
    feat_brake_rate = DW'(brake);
    data_valid      = dv;
    alarm_ack       = ack;
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs against the expected state; warn/crit are decoded from it.
  task automatic checkOutput(input string tag, input logic [1:0] exp_state,
                             input logic [1:0] exp_fault, input int exp_events_en);
    logic       exp_warn;
    logic       exp_crit;
    logic [7:0] exp_events;
    exp_warn = (exp_state == 2'd1);
    exp_crit = (exp_state == 2'd2) || (exp_state == 2'd3);
`ifdef SAFETY_EVT_COUNT_EN
    exp_events = 8'(exp_events_en);
`else
    exp_events = 8'd0;
`endif
    checks++;
    assert (state === exp_state) else begin
      errors++;
      $error("[TB] FAIL %s state got %0d want %0d", tag, state, exp_state);
    end
    checks++;
    assert (warn === exp_warn) else begin
      errors++;
      $error("[TB] FAIL %s warn got %0b want %0b", tag, warn, exp_warn);
    end
    checks++;
    assert (crit === exp_crit) else begin
      errors++;
      $error("[TB] FAIL %s crit got %0b want %0b", tag, crit, exp_crit);
    end
    checks++;
    assert (fault_code === exp_fault) else begin
      errors++;
      $error("[TB] FAIL %s fault_code got %b want %b", tag, fault_code, exp_fault);
    end
    checks++;
    assert (crit_events === exp_events) else begin
      errors++;
      $error("[TB] FAIL %s crit_events got %0d want %0d", tag, crit_events, exp_events);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    feat_accel_mag  = '0;
    feat_brake_rate = '0;
    data_valid      = 1'b0;
    alarm_ack       = 1'b0;

    applyStimulus(0, 0, 1'b0, 1'b1);
    applyStimulus(1300, 950, 1'b1, 1'b1);
    checkOutput("reset", 2'd0, 2'b00, 0);
    rst_n = 1'b1;

    $display("[TB] quiet samples and sub-threshold boundary");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(100, 100, 1'b1, 1'b0);
      checkOutput("quiet", 2'd0, 2'b00, 0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(799, 499, 1'b1, 1'b0);
      checkOutput("below_warn", 2'd0, 2'b00, 0);
    end

    $display("[TB] warn escalation and clear");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(900, 0, 1'b1, 1'b0);
      checkOutput("warn_run", 2'd0, 2'b00, 0);
    end
    applyStimulus(900, 0, 1'b1, 1'b0);
    checkOutput("warn_enter", 2'd1, 2'b00, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(100, 0, 1'b1, 1'b0);
      checkOutput("warn_clear_run", 2'd1, 2'b00, 0);
    end
    applyStimulus(100, 0, 1'b1, 1'b0);
    checkOutput("warn_cleared", 2'd0, 2'b00, 0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(800, 0, 1'b1, 1'b0);
      checkOutput("warn_edge_run", 2'd0, 2'b00, 0);
    end
    applyStimulus(800, 0, 1'b1, 1'b0);
    checkOutput("warn_edge_enter", 2'd1, 2'b00, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(100, 0, 1'b1, 1'b0);
      checkOutput("warn_hold_low", 2'd1, 2'b00, 0);
    end
    applyStimulus(900, 0, 1'b1, 1'b0);
    checkOutput("warn_clear_broken", 2'd1, 2'b00, 0);

    $display("[TB] broken crit run then brake crit");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 950, 1'b1, 1'b0);
      checkOutput("brake_run_a", 2'd1, 2'b00, 0);
    end
    applyStimulus(0, 100, 1'b1, 1'b0);
    checkOutput("brake_break", 2'd1, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 950, 1'b1, 1'b0);
      checkOutput("brake_run_b", 2'd1, 2'b00, 0);
    end
    applyStimulus(0, 950, 1'b1, 1'b0);
    checkOutput("brake_crit_enter", 2'd2, 2'b10, 1);

    $display("[TB] ack ignored in CRIT, clear to HOLD");
    applyStimulus(0, 0, 1'b0, 1'b1);
    checkOutput("crit_ack_ignored", 2'd2, 2'b10, 1);
    applyStimulus(0, 0, 1'b0, 1'b1);
    checkOutput("crit_ack_ignored2", 2'd2, 2'b10, 1);
    applyStimulus(1199, 0, 1'b1, 1'b0);
    checkOutput("crit_clear_edge", 2'd2, 2'b10, 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(100, 0, 1'b1, 1'b0);
      checkOutput("crit_clear_run", 2'd2, 2'b10, 1);
    end
    applyStimulus(100, 0, 1'b1, 1'b0);
    checkOutput("hold_enter", 2'd3, 2'b10, 1);

    $display("[TB] re-crit in HOLD beats simultaneous ack");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1300, 0, 1'b1, 1'b0);
      checkOutput("hold_crit_run", 2'd3, 2'b10, 1);
    end
    applyStimulus(1300, 0, 1'b1, 1'b1);
    checkOutput("hold_recrit", 2'd2, 2'b01, 2);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(100, 100, 1'b1, 1'b0);
      checkOutput("crit_clear_run2", 2'd2, 2'b01, 2);
    end
    applyStimulus(100, 100, 1'b1, 1'b0);
    checkOutput("hold_enter2", 2'd3, 2'b01, 2);
    applyStimulus(0, 0, 1'b0, 1'b0);
    checkOutput("hold_no_ack", 2'd3, 2'b01, 2);
    applyStimulus(0, 0, 1'b0, 1'b1);
    checkOutput("hold_ack", 2'd0, 2'b00, 2);

    $display("[TB] simultaneous crit and warn from NORMAL at exact thresholds");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1200, 900, 1'b1, 1'b0);
      checkOutput("both_run", 2'd0, 2'b00, 2);
    end
    applyStimulus(1200, 900, 1'b1, 1'b0);
    checkOutput("both_crit", 2'd2, 2'b11, 3);

    $display("[TB] reset mid-alarm");
    rst_n = 1'b0;
    applyStimulus(1300, 950, 1'b1, 1'b1);
    checkOutput("reset_mid_alarm", 2'd0, 2'b00, 0);
    rst_n = 1'b1;

    $display("[TB] data_valid gaps inside a persistence run");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(900, 0, 1'b1, 1'b0);
      checkOutput("gap_run_a", 2'd0, 2'b00, 0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(100, 0, 1'b0, 1'b1);
      checkOutput("gap_idle", 2'd0, 2'b00, 0);
    end
    applyStimulus(900, 0, 1'b1, 1'b0);
    checkOutput("gap_run_b", 2'd0, 2'b00, 0);
    applyStimulus(900, 0, 1'b1, 1'b0);
    checkOutput("gap_warn_enter", 2'd1, 2'b00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
